fetch_sequencer: RTL and testbench

Fetch controller that sequences the 4096-entry, 19-bit-wide instruction memory. The memory has one-cycle synchronous read latency and no enable: it re-reads on every clock edge. The block owns the program counter and drives the memory address. It tracks the outstanding read, captures each returned word in the cycle after issue, and presents instruction/PC pairs to decode over a valid/ready handshake. It sits between the instruction memory and the decode stage and handles stalls, branch/jump redirects and run/halt control.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo2.sv | 66 ++++++
 rtl/fetch_sequencer.sv | 147 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM state and FIFO entry types for the fetch unit.
// Also holds a saturating counter helper used when FETCH_PERF_COUNTERS_EN is defined.
package fetch_pkg;

    localparam int ADDR_WIDTH  = 12;
    localparam int INSTR_WIDTH = 19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instruction;
        logic [ADDR_WIDTH-1:0]  pc;
    } fetch_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                            input logic        en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/fetch_fifo2.sv
// fetch_fifo2: two-entry FIFO of {instruction, pc} with flush; slot0 is the head.
// Ports: clock, reset_n, push/push_entry, pop, flush in; count, head out.
module fetch_fifo2
    import fetch_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t slot0_q, slot0_d;
    fetch_entry_t slot1_q, slot1_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) slot0_d = push_entry;
                    else                 slot1_d = push_entry;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    slot0_d = slot1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind what remains.
                    if (count_q == 2'd2) begin
                        slot0_d = slot1_q;
                        slot1_d = push_entry;
                    end else begin
                        slot0_d = push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = slot0_q;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, issues reads to a 1-cycle sync memory, queues
// returned words and hands {instruction, pc} to decode over valid/ready.
// Ports: clock, reset_n, run, redirect_valid/target, mem_address/mem_instruction,
// out_valid/out_ready/out_instruction/out_pc, busy.
// Macro FETCH_PERF_COUNTERS_EN adds perf_fetched, perf_squashed, perf_stall.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   run,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_target,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    input  logic [INSTR_WIDTH-1:0] mem_instruction,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instruction,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic                   busy
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_squashed,
    output logic [31:0]            perf_stall
`endif
);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic                  inflight_q, inflight_d;

    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic         pop;
    logic         push;
    logic         room;
    logic         issue;

    assign mem_address = redirect_valid ? redirect_target : pc_q;
    assign out_valid   = (count != 2'd0);
    assign pop         = out_valid & out_ready;
    // A redirect squashes the read in flight, so its word is dropped.
    assign push        = inflight_q & ~redirect_valid;

    assign push_entry.instruction = mem_instruction;
    assign push_entry.pc          = inflight_pc_q;

    // Queued + in-flight words after this cycle's pop must fit in two slots,
    // so a stalled decode can never cause a returned word to be dropped.
    assign room = ({1'b0, count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

    // A redirect flushes the FIFO and squashes the in-flight read, leaving
    // both slots free, so the target can always go out when run is high.
    assign issue = run & (redirect_valid | ((state_q == FETCH) & room));

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (issue) begin
            inflight_pc_d = mem_address;
            pc_d          = mem_address + 1'b1;
        end else if (redirect_valid) begin
            pc_d = redirect_target;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                if (!run) state_d = inflight_q ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (run)              state_d = FETCH;
                else if (!inflight_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo2 u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (count),
        .head       (head)
    );

    assign out_instruction = head.instruction;
    assign out_pc          = head.pc;
    assign busy            = (state_q != IDLE) | out_valid;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetched_q,  perf_fetched_d;
    logic [31:0] perf_squashed_q, perf_squashed_d;
    logic [31:0] perf_stall_q,    perf_stall_d;

    always_comb begin
        perf_fetched_d  = sat_inc(perf_fetched_q, push);
        perf_squashed_d = sat_inc(perf_squashed_q, inflight_q & redirect_valid);
        perf_stall_d    = sat_inc(perf_stall_q, out_valid & ~out_ready);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
            perf_stall_q    <= '0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_squashed_q <= perf_squashed_d;
            perf_stall_q    <= perf_stall_d;
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
    assign perf_stall    = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench for fetch_sequencer.
// Expected stream = contiguous addresses from the latest redirect/reset point.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic                   run;
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_target;
    logic [ADDR_WIDTH-1:0]  mem_address;
    logic [INSTR_WIDTH-1:0] mem_instruction;
    logic                   out_valid;
    logic                   out_ready;
    logic [INSTR_WIDTH-1:0] out_instruction;
    logic [ADDR_WIDTH-1:0]  out_pc;
    logic                   busy;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetched, perf_squashed, perf_stall;
`endif

    fetch_sequencer dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .run             (run),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .mem_address     (mem_address),
        .mem_instruction (mem_instruction),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .busy            (busy)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_squashed   (perf_squashed),
        .perf_stall      (perf_stall)
`endif
    );

    always #5 clock = ~clock;

    logic [INSTR_WIDTH-1:0] mem [4096];
    always @(posedge clock) mem_instruction <= mem[mem_address];

    fetch_entry_t          exp_q[$];
    logic [ADDR_WIDTH-1:0] next_pc;
    int vectors     = 0;
    int miscompares = 0;
    int pops        = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake must deliver the next expected word.
    always @(negedge clock) begin
        fetch_entry_t e;
        if (reset_n && out_valid && out_ready) begin
            pops++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_unexpected: got pc %0h, nothing expected", out_pc);
            end else begin
                e = exp_q.pop_front();
                if (out_pc !== e.pc || out_instruction !== e.instruction) begin
                    miscompares++;
                    $display("FAIL pop_word: got pc %0h instr %0h expected pc %0h instr %0h",
                             out_pc, out_instruction, e.pc, e.instruction);
                end
            end
        end
    end

    task automatic topup();
        fetch_entry_t t;
        while (exp_q.size() < 8) begin
            t.pc          = next_pc;
            t.instruction = mem[next_pc];
            exp_q.push_back(t);
            next_pc = next_pc + 12'd1;
        end
    endtask

    task automatic restart(input logic [ADDR_WIDTH-1:0] start);
        exp_q.delete();
        next_pc = start;
        topup();
    endtask

    // One cycle: drive, cross the edge, then fold a redirect into the model.
    task automatic step(input bit r, input bit rv,
                        input logic [ADDR_WIDTH-1:0] tgt, input bit rdy);
        run             = r;
        redirect_valid  = rv;
        redirect_target = tgt;
        out_ready       = rdy;
        @(posedge clock);
        #1;
        redirect_valid = 1'b0;
        if (rv) restart(tgt);
        else    topup();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        int sq0;
        logic [ADDR_WIDTH-1:0] held_pc, held_addr;
        foreach (mem[i]) mem[i] = 19'($urandom);
        reset_n = 1'b0; run = 1'b0; redirect_valid = 1'b0;
        redirect_target = '0; out_ready = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pc", 32'(out_pc), 0);
        check("rst_instr", 32'(out_instruction), 0);
        check("rst_addr", 32'(mem_address), 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        restart('0);

        repeat (10) step(1, 0, '0, 1);
        p0 = pops;
        repeat (10) step(1, 0, '0, 1);
        check("throughput", 32'(pops - p0), 10);

        for (int i = 0; i < 5; i++) begin
            step(1, 0, '0, 0);
            if (i == 1) begin
                held_pc   = out_pc;
                held_addr = mem_address;
            end
            if (i >= 2) begin
                check("stall_valid", 32'(out_valid), 1);
                check("stall_head", 32'(out_pc), 32'(held_pc));
                check("stall_issue", 32'(mem_address), 32'(held_addr));
            end
        end
        p0 = pops;
        repeat (10) step(1, 0, '0, 1);
        check("resume_rate", 32'(pops - p0), 10);

`ifdef FETCH_PERF_COUNTERS_EN
        sq0 = int'(perf_squashed);
`else
        sq0 = 0;
`endif
        step(1, 1, 12'd100, 1);
        check("redir_flush", 32'(out_valid), 0);
`ifdef FETCH_PERF_COUNTERS_EN
        check("perf_squashed", perf_squashed, 32'(sq0 + 1));
`endif
        step(1, 0, '0, 1);
        check("redir_valid", 32'(out_valid), 1);
        check("redir_pc", 32'(out_pc), 100);
        repeat (5) step(1, 0, '0, 1);

        step(1, 1, 12'd200, 1);
        step(1, 1, 12'd300, 1);
        repeat (6) step(1, 0, '0, 1);

        step(1, 1, 12'd4095, 1);
        step(1, 0, '0, 1);
        check("wrap_first", 32'(out_pc), 4095);
        step(1, 0, '0, 1);
        check("wrap_second", 32'(out_pc), 0);
        repeat (4) step(1, 0, '0, 1);

        step(0, 0, '0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, '0, 0);
            check("drain_busy", 32'(busy), 1);
            check("drain_held", 32'(out_valid), 1);
        end
        for (int i = 0; i < 10 && busy; i++) step(0, 0, '0, 1);
        check("drain_idle", 32'(busy), 0);

        for (int i = 0; i < 2000; i++) begin
            bit rv;
            logic [ADDR_WIDTH-1:0] tgt;
            rv  = ($urandom_range(0, 19) == 0);
            tgt = ($urandom_range(0, 4) == 0) ? 12'd4095 : 12'($urandom);
            step($urandom_range(0, 9) != 0, rv, tgt, $urandom_range(0, 3) != 0);
        end

        repeat (6) step(1, 0, '0, 1);
        repeat (4) step(1, 0, '0, 0);
        reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_addr", 32'(mem_address), 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        restart('0);
        p0 = pops;
        repeat (20) step(1, 0, '0, 1);
        check("arst_restart", 32'(pops - p0 >= 15), 1);

        for (int i = 0; i < 20 && busy; i++) step(0, 0, '0, 1);
        check("final_idle", 32'(busy), 0);
        check("liveness", 32'(pops > 500), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
